// File: rtl/note_detector.sv
// note_detector: measures the full period of a square-wave tone line and
// reports which C5..B5 note it matches once two consecutive periods agree.
module note_detector #(
  parameter int TOL     = 500,     // accepted +/- deviation from a nominal period
  parameter int TIMEOUT = 200000,  // cycles without a rising edge => silent
  parameter int W       = 18       // counter/period width, 2**W > TIMEOUT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         tone_in,
  output logic [W-1:0] period,
  output logic         period_stb,
  output logic [3:0]   note_idx,
  output logic         note_valid,
  output logic         silent
);

  localparam logic [3:0]   NO_NOTE  = 4'hF;
  localparam logic [W-1:0] CNT_LAST = W'(TIMEOUT - 1);

  // Nominal full periods in clk cycles, C5 first.
  localparam int unsigned NOMINAL [12] = '{
    95604, 90254, 85180, 80386, 75874, 71634,
    67568, 63776, 60170, 56820, 53650, 50608
  };

  logic         sync1_q, sync1_d;
  logic         sync2_q, sync2_d;
  logic         sync3_q, sync3_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic         armed_q, armed_d;
  logic [3:0]   cand_q, cand_d;
  logic [W-1:0] period_q, period_d;
  logic         period_stb_q, period_stb_d;
  logic [3:0]   note_idx_q, note_idx_d;
  logic         note_valid_q, note_valid_d;
  logic         silent_q, silent_d;
  logic         rise;
  logic [3:0]   cls;

  // Map a period onto the note whose inclusive tolerance window contains it.
  function automatic logic [3:0] classify(input logic [W-1:0] p);
    int unsigned pv;
    logic [3:0]  idx;
    pv  = 32'(p);
    idx = NO_NOTE;
    for (int i = 0; i < 12; i++) begin
      if (pv + 32'(TOL) >= NOMINAL[i] && pv <= NOMINAL[i] + 32'(TOL))
        idx = i[3:0];
    end
    return idx;
  endfunction

  // Next-state logic: sync chain, period counter, arming, confirmation, silence.
  always_comb begin
    // NOTE: every signal gets its default up front, so no path leaves one
    // unassigned and no latch is inferred.
    sync1_d      = tone_in;
    sync2_d      = sync1_q;
    sync3_d      = sync2_q;
    cnt_d        = cnt_q;
    armed_d      = armed_q;
    cand_d       = cand_q;
    period_d     = period_q;
    period_stb_d = 1'b0;
    note_idx_d   = note_idx_q;
    note_valid_d = note_valid_q;
    silent_d     = silent_q;

    rise = sync2_q & ~sync3_q;
    cls  = classify(period_q);

    // A fresh period was published last cycle: confirm against the candidate.
    if (period_stb_q) begin
      if (cls != NO_NOTE && cls == cand_q) begin
        note_idx_d   = cls;
        note_valid_d = 1'b1;
      end else begin
        note_idx_d   = NO_NOTE;
        note_valid_d = 1'b0;
      end
      cand_d = cls;
    end

    // An edge in the saturation cycle still counts as a measurement.
    if (rise) begin
      cnt_d    = '0;
      silent_d = 1'b0;
      armed_d  = 1'b1;
      if (armed_q) begin
        period_d     = cnt_q + W'(1);
        period_stb_d = 1'b1;
      end
    end else if (cnt_q != CNT_LAST) begin
      cnt_d = cnt_q + W'(1);
    end else begin
      silent_d     = 1'b1;
      armed_d      = 1'b0;
      cand_d       = NO_NOTE;
      note_idx_d   = NO_NOTE;
      note_valid_d = 1'b0;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      sync3_q      <= 1'b0;
      cnt_q        <= '0;
      armed_q      <= 1'b0;
      cand_q       <= NO_NOTE;
      period_q     <= '0;
      period_stb_q <= 1'b0;
      note_idx_q   <= NO_NOTE;
      note_valid_q <= 1'b0;
      silent_q     <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      sync3_q      <= sync3_d;
      cnt_q        <= cnt_d;
      armed_q      <= armed_d;
      cand_q       <= cand_d;
      period_q     <= period_d;
      period_stb_q <= period_stb_d;
      note_idx_q   <= note_idx_d;
      note_valid_q <= note_valid_d;
      silent_q     <= silent_d;
    end
  end

  assign period     = period_q;
  assign period_stb = period_stb_q;
  assign note_idx   = note_idx_q;
  assign note_valid = note_valid_q;
  assign silent     = silent_q;

endmodule

// File: tb/tb_note_detector.sv
// Directed bench for note_detector: lock, note change, tolerance edges,
// out-of-band periods, silence and reset in mid-measurement.
module tb_note_detector;

  localparam int TOL     = 500;
  localparam int TIMEOUT = 200000;
  localparam int W       = 18;

  logic         clk = 1'b0;
  logic         reset;
  logic         tone_in;
  logic [W-1:0] period;
  logic         period_stb;
  logic [3:0]   note_idx;
  logic         note_valid;
  logic         silent;

  int n_cmp = 0;
  int n_err = 0;

  note_detector #(.TOL(TOL), .TIMEOUT(TIMEOUT), .W(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .tone_in    (tone_in),
    .period     (period),
    .period_stb (period_stb),
    .note_idx   (note_idx),
    .note_valid (note_valid),
    .silent     (silent)
  );

  always #10 clk = ~clk;  // 50 MHz

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".period"},     32'(period),     32'd0);
    check({tag, ".period_stb"}, 32'(period_stb), 32'd0);
    check({tag, ".note_idx"},   32'(note_idx),   32'd15);
    check({tag, ".note_valid"}, 32'(note_valid), 32'd0);
    check({tag, ".silent"},     32'(silent),     32'd1);
  endtask

  // Raise tone_in at a negedge and check the strobe (3 clk edges later) and
  // the note outputs (one edge after that). Returns 4 cycles after the rise.
  task automatic rise_check(input string tag, input bit exp_stb, input int exp_per,
                            input int exp_idx, input bit exp_val);
    tone_in = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check({tag, ".stb"},    32'(period_stb), 32'(exp_stb));
    check({tag, ".period"}, 32'(period),     32'(exp_per));
    @(posedge clk);
    @(negedge clk);
    check({tag, ".stb_off"},    32'(period_stb), 32'd0);
    check({tag, ".note_idx"},   32'(note_idx),   32'(exp_idx));
    check({tag, ".note_valid"}, 32'(note_valid), 32'(exp_val));
    check({tag, ".silent"},     32'(silent),     32'd0);
  endtask

  // Complete a full period of p cycles begun by rise_check.
  task automatic finish_period(input int p);
    int h;
    h = p / 2;
    repeat (h - 4) @(negedge clk);
    tone_in = 1'b0;
    repeat (p - h) @(negedge clk);
  endtask

  task automatic tone_cycle(input string tag, input int p, input bit exp_stb,
                            input int exp_per, input int exp_idx, input bit exp_val);
    rise_check(tag, exp_stb, exp_per, exp_idx, exp_val);
    finish_period(p);
  endtask

  initial begin
    reset   = 1'b1;
    tone_in = 1'b0;
    repeat (4) @(negedge clk);
    check_reset_values("reset");
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("idle.silent", 32'(silent), 32'd1);

    // D#5 lock: first edge arms, third edge confirms.
    tone_cycle("ds5_arm",   80386, 1'b0, 0,     15, 1'b0);
    tone_cycle("ds5_p1",    80386, 1'b1, 80386, 15, 1'b0);
    tone_cycle("ds5_lock",  80386, 1'b1, 80386, 3,  1'b1);

    // Note change to A5.
    tone_cycle("ds5_last",  56820, 1'b1, 80386, 3,  1'b1);
    tone_cycle("a5_first",  56820, 1'b1, 56820, 15, 1'b0);
    tone_cycle("a5_lock",   80886, 1'b1, 56820, 9,  1'b1);

    // Tolerance edges around D#5 (80386 +/- 500 inclusive).
    tone_cycle("tol_in1",   80886, 1'b1, 80886, 15, 1'b0);
    tone_cycle("tol_in2",   80887, 1'b1, 80886, 3,  1'b1);
    tone_cycle("tol_out1",  80887, 1'b1, 80887, 15, 1'b0);
    tone_cycle("tol_out2",  70000, 1'b1, 80887, 15, 1'b0);

    // Out-of-band steady period.
    tone_cycle("oob1",      70000, 1'b1, 70000, 15, 1'b0);
    tone_cycle("oob2",      80386, 1'b1, 70000, 15, 1'b0);

    // Relock to D#5, then stop toggling.
    tone_cycle("relock1",   80386, 1'b1, 80386, 15, 1'b0);
    rise_check("relock2",          1'b1, 80386, 3,  1'b1);
    repeat (100) @(negedge clk);
    tone_in = 1'b0;
    repeat (TIMEOUT - 102) @(negedge clk);
    check("pre_silence.silent",     32'(silent),     32'd0);
    check("pre_silence.note_valid", 32'(note_valid), 32'd1);
    @(negedge clk);
    check("silence.silent",     32'(silent),     32'd1);
    check("silence.note_valid", 32'(note_valid), 32'd0);
    check("silence.note_idx",   32'(note_idx),   32'd15);
    check("silence.period",     32'(period),     32'd80386);
    repeat (1000) @(negedge clk);

    // First edge after silence only re-arms; two periods relock.
    tone_cycle("wake_arm",  80386, 1'b0, 80386, 15, 1'b0);
    tone_cycle("wake_p1",   80386, 1'b1, 80386, 15, 1'b0);
    rise_check("wake_lock",        1'b1, 80386, 3,  1'b1);

    // Reset halfway through a locked period.
    repeat (40000) @(negedge clk);
    reset   = 1'b1;
    tone_in = 1'b0;
    #1;
    check_reset_values("mid_reset");
    repeat (5) @(negedge clk);
    reset = 1'b0;
    repeat (100) @(negedge clk);
    tone_cycle("post_arm",  80386, 1'b0, 0,     15, 1'b0);
    tone_cycle("post_p1",   80386, 1'b1, 80386, 15, 1'b0);
    rise_check("post_lock",        1'b1, 80386, 3,  1'b1);
    repeat (10) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
